// File: rtl/bp_axi_nbf_receiver_if.sv
// AXI-Lite write channels between the host fabric and the NBF receiver.
interface bp_axi_nbf_receiver_if #(
    parameter int S_AXIL_ADDR_WIDTH = 64,
    parameter int S_AXIL_DATA_WIDTH = 32
);
    logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_awaddr;
    logic                         s_axil_awvalid;
    logic                         s_axil_awready;
    logic [2:0]                   s_axil_awprot;
    logic [S_AXIL_DATA_WIDTH-1:0] s_axil_wdata;
    logic                         s_axil_wvalid;
    logic                         s_axil_wready;
    logic [3:0]                   s_axil_wstrb;
    logic                         s_axil_bvalid;
    logic                         s_axil_bready;
    logic [1:0]                   s_axil_bresp;

    modport master (
        output s_axil_awaddr, s_axil_awvalid, s_axil_awprot,
        output s_axil_wdata, s_axil_wvalid, s_axil_wstrb, s_axil_bready,
        input  s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp
    );

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, s_axil_awprot,
        input  s_axil_wdata, s_axil_wvalid, s_axil_wstrb, s_axil_bready,
        output s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp
    );
endinterface

// File: rtl/bp_axi_nbf_receiver.sv
// AXI-Lite write-only responder reassembling 136-bit NBF commands from five 32-bit writes.
// Optional BP_AXI_NBF_RECEIVER_WSTRB_CHECK_EN: matched writes with partial strobes get SLVERR.
module bp_axi_nbf_receiver #(
    parameter int          S_AXIL_ADDR_WIDTH = 64,
    parameter int          S_AXIL_DATA_WIDTH = 32,
    parameter logic [63:0] nbf_host_addr_p   = 64'h0
) (
    input  logic                 s_axil_aclk,
    input  logic                 s_axil_aresetn,
    bp_axi_nbf_receiver_if.slave s_axil,
    output logic                 nbf_v_o,
    input  logic                 nbf_ready_and_i,
    output logic [7:0]           nbf_opcode_o,
    output logic [63:0]          nbf_addr_o,
    output logic [63:0]          nbf_data_o,
    output logic                 done_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                         ready_en_r;
    logic                         aw_full_r, w_full_r;
    logic [S_AXIL_ADDR_WIDTH-1:0] awaddr_r;
    logic [31:0]                  wdata_r;
    logic [3:0]                   wstrb_r;
    logic                         bvalid_r;
    logic [1:0]                   bresp_r;
    logic [2:0]                   word_r;
    logic [31:0]                  flit0_r, flit1_r, flit2_r, flit3_r;
    logic                         nbf_v_r;
    logic [7:0]                   opcode_r;
    logic [63:0]                  addr_r, data_r;
    logic                         done_r;

    logic aw_fire, w_fire, addr_match, stall, commit, store_ok, xfer, strb_ok;

`ifdef BP_AXI_NBF_RECEIVER_WSTRB_CHECK_EN
    assign strb_ok = (wstrb_r == 4'hF);
`else
    assign strb_ok = 1'b1;
    logic unused_wstrb;
    assign unused_wstrb = &{1'b0, wstrb_r};
`endif

    logic unused_awprot;
    assign unused_awprot = &{1'b0, s_axil.s_axil_awprot};

    assign s_axil.s_axil_awready = ready_en_r & ~aw_full_r & ~bvalid_r;
    assign s_axil.s_axil_wready  = ready_en_r & ~w_full_r & ~bvalid_r;
    assign s_axil.s_axil_bvalid  = bvalid_r;
    assign s_axil.s_axil_bresp   = bresp_r;

    always_comb begin
        aw_fire    = s_axil.s_axil_awvalid & s_axil.s_axil_awready;
        w_fire     = s_axil.s_axil_wvalid & s_axil.s_axil_wready;
        addr_match = (awaddr_r == S_AXIL_ADDR_WIDTH'(nbf_host_addr_p));
        xfer       = nbf_v_r & nbf_ready_and_i;
        // The output command has its own register, so flit0 of the next command may
        // land while the previous one waits; later flits hold until it drains.
        stall      = addr_match & nbf_v_r & ~nbf_ready_and_i & (word_r != 3'd0);
        commit     = aw_full_r & w_full_r & ~bvalid_r & ~stall;
        store_ok   = addr_match & ~done_r & strb_ok;
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            ready_en_r <= 1'b0;
            aw_full_r  <= 1'b0;
            w_full_r   <= 1'b0;
            awaddr_r   <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            word_r     <= '0;
            flit0_r    <= '0;
            flit1_r    <= '0;
            flit2_r    <= '0;
            flit3_r    <= '0;
            nbf_v_r    <= 1'b0;
            opcode_r   <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            done_r     <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (aw_fire) begin
                aw_full_r <= 1'b1;
                awaddr_r  <= s_axil.s_axil_awaddr;
            end
            if (w_fire) begin
                w_full_r <= 1'b1;
                wdata_r  <= s_axil.s_axil_wdata[31:0];
                wstrb_r  <= s_axil.s_axil_wstrb;
            end
            if (commit) begin
                aw_full_r <= 1'b0;
                w_full_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= store_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_r && s_axil.s_axil_bready) begin
                bvalid_r <= 1'b0;
            end

            if (xfer) begin
                nbf_v_r <= 1'b0;
                if (opcode_r == 8'hFF) done_r <= 1'b1;
            end
            if (commit && store_ok) begin
                case (word_r)
                    3'd0: flit0_r <= wdata_r;
                    3'd1: flit1_r <= wdata_r;
                    3'd2: flit2_r <= wdata_r;
                    3'd3: flit3_r <= wdata_r;
                    default: begin
                        data_r   <= {flit1_r, flit0_r};
                        addr_r   <= {flit3_r, flit2_r};
                        opcode_r <= wdata_r[7:0];
                        nbf_v_r  <= 1'b1;
                    end
                endcase
                word_r <= (word_r == 3'd4) ? 3'd0 : word_r + 3'd1;
            end
        end
    end

    assign nbf_v_o      = nbf_v_r;
    assign nbf_opcode_o = opcode_r;
    assign nbf_addr_o   = addr_r;
    assign nbf_data_o   = data_r;
    assign done_o       = done_r;
endmodule

// File: tb/tb_bp_axi_nbf_receiver.sv
// Directed self-checking bench for bp_axi_nbf_receiver.
module tb_bp_axi_nbf_receiver;
    logic        clk;
    logic        rst_n;
    logic        nbf_v, nbf_ready, done;
    logic [7:0]  nbf_opcode;
    logic [63:0] nbf_addr, nbf_data;
    int checks = 0;
    int failures = 0;

    bp_axi_nbf_receiver_if #(.S_AXIL_ADDR_WIDTH(64), .S_AXIL_DATA_WIDTH(32)) axil();

    bp_axi_nbf_receiver #(
        .S_AXIL_ADDR_WIDTH(64), .S_AXIL_DATA_WIDTH(32), .nbf_host_addr_p(64'h0)
    ) dut (
        .s_axil_aclk(clk),
        .s_axil_aresetn(rst_n),
        .s_axil(axil),
        .nbf_v_o(nbf_v),
        .nbf_ready_and_i(nbf_ready),
        .nbf_opcode_o(nbf_opcode),
        .nbf_addr_o(nbf_addr),
        .nbf_data_o(nbf_data),
        .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives AW and W together, waits for B and returns bresp (x on timeout).
    task automatic axil_write(input logic [63:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        bit aw_p, w_p, aw_f, w_f;
        axil.s_axil_awaddr  = a;
        axil.s_axil_wdata   = d;
        axil.s_axil_wstrb   = 4'hF;
        axil.s_axil_awvalid = 1'b1;
        axil.s_axil_wvalid  = 1'b1;
        aw_p = 1'b1;
        w_p  = 1'b1;
        n    = 0;
        while ((aw_p || w_p) && n < 50) begin
            aw_f = axil.s_axil_awvalid && axil.s_axil_awready;
            w_f  = axil.s_axil_wvalid && axil.s_axil_wready;
            cyc();
            n++;
            if (aw_f) begin axil.s_axil_awvalid = 1'b0; aw_p = 1'b0; end
            if (w_f)  begin axil.s_axil_wvalid  = 1'b0; w_p  = 1'b0; end
        end
        axil.s_axil_awvalid = 1'b0;
        axil.s_axil_wvalid  = 1'b0;
        resp = 2'bxx;
        n = 0;
        while (axil.s_axil_bvalid !== 1'b1 && n < 50) begin cyc(); n++; end
        if (axil.s_axil_bvalid === 1'b1) begin
            resp = axil.s_axil_bresp;
            axil.s_axil_bready = 1'b1;
            cyc();
            axil.s_axil_bready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++; if (axil.s_axil_awready !== 1'b0) begin failures++; $display("FAIL reset_awready got=%0b exp=0", axil.s_axil_awready); end
        checks++; if (axil.s_axil_wready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%0b exp=0", axil.s_axil_wready); end
        checks++; if (axil.s_axil_bvalid !== 1'b0 || axil.s_axil_bresp !== 2'b00) begin failures++; $display("FAIL reset_b got=%0b/%0b exp=0/0", axil.s_axil_bvalid, axil.s_axil_bresp); end
        checks++; if (nbf_v !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_nbf got=%0b/%0b exp=0/0", nbf_v, done); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++; if (axil.s_axil_awready !== 1'b1 || axil.s_axil_wready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b/%0b exp=1/1", axil.s_axil_awready, axil.s_axil_wready); end
    endtask

    task automatic test_basic();
        logic [31:0] w [5];
        logic [1:0] r;
        w[0] = 32'h89ABCDEF; w[1] = 32'h01234567; w[2] = 32'h80000000; w[3] = 32'h0; w[4] = 32'h00000002;
        for (int i = 0; i < 5; i++) begin
            axil_write(64'h0, w[i], r);
            checks++; if (r !== 2'b00) begin failures++; $display("FAIL basic_resp%0d got=%b exp=00", i, r); end
        end
        checks++; if (nbf_v !== 1'b1) begin failures++; $display("FAIL basic_v got=%0b exp=1", nbf_v); end
        checks++; if (nbf_opcode !== 8'h02 || nbf_addr !== 64'h80000000 || nbf_data !== 64'h0123456789ABCDEF) begin
            failures++; $display("FAIL basic_cmd got=%h/%h/%h exp=02/0000000080000000/0123456789abcdef", nbf_opcode, nbf_addr, nbf_data); end
        cyc();
        checks++; if (nbf_v !== 1'b1 || nbf_opcode !== 8'h02) begin failures++; $display("FAIL basic_hold got=%0b/%h exp=1/02", nbf_v, nbf_opcode); end
        nbf_ready = 1'b1;
        cyc();
        nbf_ready = 1'b0;
        checks++; if (nbf_v !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_xfer got=%0b/%0b exp=0/0", nbf_v, done); end
    endtask

    task automatic test_w_first_bhold();
        logic [1:0] r;
        axil.s_axil_wdata  = 32'h0000_00AA;
        axil.s_axil_wstrb  = 4'hF;
        axil.s_axil_wvalid = 1'b1;
        cyc();
        axil.s_axil_wvalid = 1'b0;
        checks++; if (axil.s_axil_wready !== 1'b0 || axil.s_axil_awready !== 1'b1 || axil.s_axil_bvalid !== 1'b0) begin
            failures++; $display("FAIL wfirst_capture got=w%0b/aw%0b/b%0b exp=0/1/0", axil.s_axil_wready, axil.s_axil_awready, axil.s_axil_bvalid); end
        repeat (2) cyc();
        axil.s_axil_awaddr  = 64'h0;
        axil.s_axil_awvalid = 1'b1;
        cyc();
        axil.s_axil_awvalid = 1'b0;
        cyc();
        checks++; if (axil.s_axil_bvalid !== 1'b1) begin failures++; $display("FAIL wfirst_bvalid got=%0b exp=1", axil.s_axil_bvalid); end
        // Second write presented while B is held off.
        axil.s_axil_awaddr  = 64'h0;
        axil.s_axil_wdata   = 32'h0000_00BB;
        axil.s_axil_awvalid = 1'b1;
        axil.s_axil_wvalid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (axil.s_axil_bvalid !== 1'b1 || axil.s_axil_bresp !== 2'b00 || axil.s_axil_awready !== 1'b0 || axil.s_axil_wready !== 1'b0) begin
                failures++; $display("FAIL bhold_c%0d got=b%0b/r%b/aw%0b/w%0b exp=1/00/0/0", i, axil.s_axil_bvalid, axil.s_axil_bresp, axil.s_axil_awready, axil.s_axil_wready); end
            cyc();
        end
        axil.s_axil_bready = 1'b1;
        cyc();
        axil.s_axil_bready = 1'b0;
        checks++; if (axil.s_axil_bvalid !== 1'b0 || axil.s_axil_awready !== 1'b1) begin failures++; $display("FAIL bhold_release got=b%0b/aw%0b exp=0/1", axil.s_axil_bvalid, axil.s_axil_awready); end
        cyc();
        axil.s_axil_awvalid = 1'b0;
        axil.s_axil_wvalid  = 1'b0;
        cyc();
        checks++; if (axil.s_axil_bvalid !== 1'b1 || axil.s_axil_bresp !== 2'b00) begin failures++; $display("FAIL second_b got=%0b/%b exp=1/00", axil.s_axil_bvalid, axil.s_axil_bresp); end
        axil.s_axil_bready = 1'b1;
        cyc();
        axil.s_axil_bready = 1'b0;
        axil_write(64'h0, 32'h0000_1000, r);
        axil_write(64'h0, 32'h0, r);
        axil_write(64'h0, 32'h0000_0001, r);
        checks++; if (nbf_v !== 1'b1 || nbf_opcode !== 8'h01 || nbf_addr !== 64'h1000 || nbf_data !== 64'h000000BB_000000AA) begin
            failures++; $display("FAIL wfirst_cmd got=%0b/%h/%h/%h exp=1/01/0000000000001000/000000bb000000aa", nbf_v, nbf_opcode, nbf_addr, nbf_data); end
        nbf_ready = 1'b1;
        cyc();
        nbf_ready = 1'b0;
    endtask

    task automatic test_mismatch();
        logic [1:0] r;
        axil_write(64'h0, 32'hCAFEF00D, r);
        axil_write(64'h0, 32'hDEADBEEF, r);
        axil_write(64'h10, 32'h12345678, r);
        checks++; if (r !== 2'b10) begin failures++; $display("FAIL mismatch_resp got=%b exp=10", r); end
        axil_write(64'h0, 32'h00000040, r);
        axil_write(64'h0, 32'h00000001, r);
        checks++; if (nbf_v !== 1'b0) begin failures++; $display("FAIL mismatch_early_v got=%0b exp=0", nbf_v); end
        axil_write(64'h0, 32'h00000003, r);
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL mismatch_flit4_resp got=%b exp=00", r); end
        checks++; if (nbf_v !== 1'b1 || nbf_opcode !== 8'h03 || nbf_addr !== 64'h00000001_00000040 || nbf_data !== 64'hDEADBEEF_CAFEF00D) begin
            failures++; $display("FAIL mismatch_cmd got=%0b/%h/%h/%h exp=1/03/0000000100000040/deadbeefcafef00d", nbf_v, nbf_opcode, nbf_addr, nbf_data); end
        nbf_ready = 1'b1;
        cyc();
        nbf_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [1:0] r;
        axil_write(64'h0, 32'h1, r);
        axil_write(64'h0, 32'h0, r);
        axil_write(64'h0, 32'h2, r);
        axil_write(64'h0, 32'h0, r);
        axil_write(64'h0, 32'h4, r);
        axil_write(64'h0, 32'h11, r);
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL stall_flit0_resp got=%b exp=00", r); end
        axil.s_axil_awaddr  = 64'h0;
        axil.s_axil_wdata   = 32'h22;
        axil.s_axil_awvalid = 1'b1;
        axil.s_axil_wvalid  = 1'b1;
        cyc();
        axil.s_axil_awvalid = 1'b0;
        axil.s_axil_wvalid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (axil.s_axil_bvalid !== 1'b0 || axil.s_axil_awready !== 1'b0 || axil.s_axil_wready !== 1'b0) begin
                failures++; $display("FAIL stall_c%0d got=b%0b/aw%0b/w%0b exp=0/0/0", i, axil.s_axil_bvalid, axil.s_axil_awready, axil.s_axil_wready); end
            checks++; if (nbf_v !== 1'b1 || nbf_opcode !== 8'h04 || nbf_addr !== 64'h2 || nbf_data !== 64'h1) begin
                failures++; $display("FAIL stall_hold%0d got=%0b/%h/%h/%h exp=1/04/2/1", i, nbf_v, nbf_opcode, nbf_addr, nbf_data); end
            cyc();
        end
        nbf_ready = 1'b1;
        cyc();
        nbf_ready = 1'b0;
        checks++; if (nbf_v !== 1'b0 || axil.s_axil_bvalid !== 1'b1 || axil.s_axil_bresp !== 2'b00) begin
            failures++; $display("FAIL stall_release got=v%0b/b%0b/r%b exp=0/1/00", nbf_v, axil.s_axil_bvalid, axil.s_axil_bresp); end
        axil.s_axil_bready = 1'b1;
        cyc();
        axil.s_axil_bready = 1'b0;
        axil_write(64'h0, 32'h33, r);
        axil_write(64'h0, 32'h44, r);
        axil_write(64'h0, 32'h05, r);
        checks++; if (nbf_v !== 1'b1 || nbf_opcode !== 8'h05 || nbf_addr !== 64'h00000044_00000033 || nbf_data !== 64'h00000022_00000011) begin
            failures++; $display("FAIL stall_cmd2 got=%0b/%h/%h/%h exp=1/05/0000004400000033/0000002200000011", nbf_v, nbf_opcode, nbf_addr, nbf_data); end
        nbf_ready = 1'b1;
        cyc();
        nbf_ready = 1'b0;
    endtask

    task automatic test_finish();
        logic [1:0] r;
        for (int i = 0; i < 4; i++) axil_write(64'h0, 32'h0, r);
        axil_write(64'h0, 32'hFF, r);
        checks++; if (nbf_v !== 1'b1 || nbf_opcode !== 8'hFF || done !== 1'b0) begin
            failures++; $display("FAIL finish_pending got=v%0b/op%h/d%0b exp=1/ff/0", nbf_v, nbf_opcode, done); end
        nbf_ready = 1'b1;
        cyc();
        nbf_ready = 1'b0;
        checks++; if (done !== 1'b1 || nbf_v !== 1'b0) begin failures++; $display("FAIL finish_done got=d%0b/v%0b exp=1/0", done, nbf_v); end
        axil_write(64'h0, 32'h0, r);
        checks++; if (r !== 2'b10) begin failures++; $display("FAIL finish_after_resp got=%b exp=10", r); end
        repeat (3) cyc();
        checks++; if (done !== 1'b1 || nbf_v !== 1'b0) begin failures++; $display("FAIL finish_sticky got=d%0b/v%0b exp=1/0", done, nbf_v); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        axil_write(64'h0, 32'hFFFF0000, r);
        axil_write(64'h0, 32'h0000FFFF, r);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (axil.s_axil_awready !== 1'b0 || axil.s_axil_wready !== 1'b0 || axil.s_axil_bvalid !== 1'b0 || axil.s_axil_bresp !== 2'b00) begin
            failures++; $display("FAIL midrst_axil got=aw%0b/w%0b/b%0b/r%b exp=0/0/0/00", axil.s_axil_awready, axil.s_axil_wready, axil.s_axil_bvalid, axil.s_axil_bresp); end
        checks++; if (nbf_v !== 1'b0 || done !== 1'b0 || nbf_opcode !== 8'h0 || nbf_addr !== 64'h0 || nbf_data !== 64'h0) begin
            failures++; $display("FAIL midrst_nbf got=v%0b/d%0b/%h/%h/%h exp=0/0/0/0/0", nbf_v, done, nbf_opcode, nbf_addr, nbf_data); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        axil_write(64'h0, 32'h12345678, r);
        axil_write(64'h0, 32'hAAAA5555, r);
        axil_write(64'h0, 32'h00000100, r);
        axil_write(64'h0, 32'h0, r);
        axil_write(64'h0, 32'h06, r);
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL midrst_resp got=%b exp=00", r); end
        checks++; if (nbf_v !== 1'b1 || nbf_opcode !== 8'h06 || nbf_addr !== 64'h100 || nbf_data !== 64'hAAAA5555_12345678) begin
            failures++; $display("FAIL midrst_cmd got=%0b/%h/%h/%h exp=1/06/0000000000000100/aaaa555512345678", nbf_v, nbf_opcode, nbf_addr, nbf_data); end
    endtask

    initial begin
        rst_n               = 1'b0;
        nbf_ready           = 1'b0;
        axil.s_axil_awaddr  = '0;
        axil.s_axil_awvalid = 1'b0;
        axil.s_axil_awprot  = 3'b0;
        axil.s_axil_wdata   = '0;
        axil.s_axil_wvalid  = 1'b0;
        axil.s_axil_wstrb   = 4'hF;
        axil.s_axil_bready  = 1'b0;
        test_reset();
        test_basic();
        test_w_first_bhold();
        test_mismatch();
        test_stall();
        test_finish();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
